// File: rtl/dmem_line_responder_if.sv
// Data-memory port and physical-memory port of the single-line responder.
// The slave modport is the responder's view; master is the core/memory side.
interface dmem_line_responder_if #(
    parameter int unsigned OFFSET_BITS = 5
);
    localparam int unsigned LINE_W = 8 << OFFSET_BITS;

    logic              dmem_read;
    logic              dmem_write;
    logic [31:0]       dmem_address;
    logic [31:0]       dmem_wdata;
    logic [3:0]        dmem_byte_enable;
    logic [31:0]       dmem_rdata;
    logic              dmem_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
        output dmem_rdata, dmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
        input  dmem_rdata, dmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/dmem_line_responder.sv
// Single-entry write-back line buffer between the MEM stage and main memory.
// Hits complete in the request cycle; misses write back (if dirty) then fill.
module dmem_line_responder #(
    parameter int unsigned OFFSET_BITS = 5
) (
    input logic                  clk,
    input logic                  rst,
    dmem_line_responder_if.slave bus
);
    localparam int unsigned LINE_W = 8 << OFFSET_BITS;
    localparam int unsigned TAG_W  = 32 - OFFSET_BITS;
    localparam int unsigned WIDX_W = OFFSET_BITS - 2;
    localparam int unsigned BIT_W  = OFFSET_BITS + 3;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } state_t;

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic              dirty_q, dirty_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [TAG_W-1:0]  miss_addr_q, miss_addr_d;
    logic [LINE_W-1:0] line_q, line_d;

    logic              dmem_resp;
    logic [31:0]       dmem_rdata;
    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [LINE_W-1:0] pmem_wdata;

    logic              request;
    logic              hit;
    logic [TAG_W-1:0]  req_tag;
    logic [WIDX_W-1:0] word_idx;
    logic [BIT_W-1:0]  word_base;
    logic [31:0]       merged_word;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^bus.dmem_address[1:0];

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        tag_d        = tag_q;
        miss_addr_d  = miss_addr_q;
        line_d       = line_q;
        dmem_resp    = 1'b0;
        dmem_rdata   = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;

        request     = bus.dmem_read || bus.dmem_write;
        req_tag     = bus.dmem_address[31:OFFSET_BITS];
        word_idx    = bus.dmem_address[OFFSET_BITS-1:2];
        word_base   = {word_idx, 5'd0};
        hit         = valid_q && (tag_q == req_tag);
        merged_word = line_q[word_base +: 32];

        for (int unsigned b = 0; b < 4; b++) begin
            if (bus.dmem_byte_enable[b]) begin
                merged_word[8*b +: 8] = bus.dmem_wdata[8*b +: 8];
            end
        end

        case (state_q)
            IDLE: begin
                if (request && !rst) begin
                    if (hit) begin
                        dmem_resp = 1'b1;
                        // A simultaneous read+write is serviced as the write.
                        if (bus.dmem_write) begin
                            line_d[word_base +: 32] = merged_word;
                            if (bus.dmem_byte_enable != '0) begin
                                dirty_d = 1'b1;
                            end
                        end else begin
                            dmem_rdata = line_q[word_base +: 32];
                        end
                    end else begin
                        miss_addr_d = req_tag;
                        state_d     = (dirty_q && valid_q) ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q, {OFFSET_BITS{1'b0}}};
                pmem_wdata   = line_q;
                if (bus.pmem_resp) begin
                    dirty_d = 1'b0;
                    state_d = FILL;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {miss_addr_q, {OFFSET_BITS{1'b0}}};
                if (bus.pmem_resp) begin
                    line_d  = bus.pmem_rdata;
                    tag_d   = miss_addr_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            dirty_q     <= 1'b0;
            tag_q       <= '0;
            miss_addr_q <= '0;
            line_q      <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            tag_q       <= tag_d;
            miss_addr_q <= miss_addr_d;
            line_q      <= line_d;
        end
    end

    assign bus.dmem_resp    = dmem_resp;
    assign bus.dmem_rdata   = dmem_rdata;
    assign bus.pmem_read    = pmem_read;
    assign bus.pmem_write   = pmem_write;
    assign bus.pmem_address = pmem_address;
    assign bus.pmem_wdata   = pmem_wdata;

    illegal_read_write: assert property (@(posedge clk) disable iff (rst)
        !(bus.dmem_read && bus.dmem_write))
        else $error("dmem_read and dmem_write asserted together");
endmodule
